cam_match_prio_enc: RTL and testbench

Pipelined, head-relative priority encoder that consumes the raw per-word match lines of the VLSU CAM and produces, per read port, a hit flag and the index of the youngest matching entry. It sits directly downstream of the CAM memory core and fills the priority-encoder stage of the VLSU CAM top. It provides one registered output stage per read port with a valid/ready handshake, so the load pipeline can stall without losing a search result.

---
 rtl/cam_match_prio_enc.sv | 89 ++++++++
 tb/tb_cam_match_prio_enc.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/cam_match_prio_enc.sv
// cam_match_prio_enc: head-relative youngest-match priority encoder with a registered valid/ready output per read port.
// Optional CAM_PRIO_MULTI_EN adds multi_o, flagging two or more matches in the accepted cycle.
module cam_match_prio_enc #(
    parameter int DEPTH = 16,
    parameter int READ  = 2,
    parameter int INDEX = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [INDEX-1:0]            head_i,
    input  logic [READ-1:0]             valid_i,
    output logic [READ-1:0]             ready_o,
    input  logic [READ-1:0][DEPTH-1:0]  match_line_i,
    output logic [READ-1:0]             valid_o,
    input  logic [READ-1:0]             ready_i,
    output logic [READ-1:0]             match_o,
    output logic [READ-1:0][INDEX-1:0]  match_idx_o
`ifdef CAM_PRIO_MULTI_EN
    ,
    output logic [READ-1:0]             multi_o
`endif
);
    logic [READ-1:0]            valid_d, valid_q, match_d, match_q, acc;
    logic [READ-1:0][INDEX-1:0] idx_d, idx_q;
    logic [INDEX-1:0]           pos, sel;
    logic                       hit, many;
`ifdef CAM_PRIO_MULTI_EN
    logic [READ-1:0]            multi_d, multi_q;
    assign multi_o = multi_q;
`endif
    assign ready_o     = ~valid_q | ready_i;
    assign acc         = valid_i & ready_o;
    assign valid_o     = valid_q;
    assign match_o     = match_q;
    assign match_idx_o = idx_q;
    // Walking age distance upward from head_i, the last hit seen is the youngest entry.
    always_comb begin
        valid_d = valid_q;
        match_d = match_q;
        idx_d   = idx_q;
`ifdef CAM_PRIO_MULTI_EN
        multi_d = multi_q;
`endif
        pos  = '0;
        sel  = '0;
        hit  = 1'b0;
        many = 1'b0;
        for (int p = 0; p < READ; p++) begin
            sel  = '0;
            hit  = 1'b0;
            many = 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                pos = INDEX'(k) + head_i;
                if (valid_i[p] && match_line_i[p][pos]) begin
                    many = many | hit;
                    hit  = 1'b1;
                    sel  = pos;
                end
            end
            if (acc[p]) begin
                valid_d[p] = 1'b1;
                match_d[p] = hit;
                idx_d[p]   = sel;
`ifdef CAM_PRIO_MULTI_EN
                multi_d[p] = many;
`endif
            end else if (ready_i[p]) begin
                valid_d[p] = 1'b0;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            match_q <= '0;
            idx_q   <= '0;
`ifdef CAM_PRIO_MULTI_EN
            multi_q <= '0;
`endif
        end else begin
            valid_q <= valid_d;
            match_q <= match_d;
            idx_q   <= idx_d;
`ifdef CAM_PRIO_MULTI_EN
            multi_q <= multi_d;
`endif
        end
    end
endmodule

// File: tb/tb_cam_match_prio_enc.sv
// tb_cam_match_prio_enc: directed checks of selection, wrap, no-hit, stall, reset and port independence at DEPTH=8, READ=2.
module tb_cam_match_prio_enc;
    logic            clk = 1'b0;
    logic            rst;
    logic [2:0]      head_i;
    logic [1:0]      valid_i, ready_o, valid_o, ready_i, match_o;
    logic [1:0][7:0] match_line_i;
    logic [1:0][2:0] match_idx_o;
    int              total = 0;
    int              bad = 0;
`ifdef CAM_PRIO_MULTI_EN
    logic [1:0]      multi_o;
`endif
    cam_match_prio_enc #(.DEPTH(8), .READ(2)) dut (
        .clk(clk),
        .rst(rst),
        .head_i(head_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .match_line_i(match_line_i),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .match_o(match_o),
        .match_idx_o(match_idx_o)
`ifdef CAM_PRIO_MULTI_EN
        ,
        .multi_o(multi_o)
`endif
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset();
        rst = 1'b1;
        head_i = '0;
        valid_i = '0;
        ready_i = '0;
        match_line_i = '0;
        tick();
        total++; if (valid_o !== 2'b00) begin bad++; $display("FAIL reset_valid got=%b exp=00", valid_o); end
        total++; if (match_o !== 2'b00) begin bad++; $display("FAIL reset_match got=%b exp=00", match_o); end
        total++; if (match_idx_o !== 6'd0) begin bad++; $display("FAIL reset_idx got=%h exp=0", match_idx_o); end
        total++; if (ready_o !== 2'b11) begin bad++; $display("FAIL reset_ready got=%b exp=11", ready_o); end
        valid_i = 2'b01;
        match_line_i[0] = 8'hff;
        tick();
        total++; if (valid_o !== 2'b00) begin bad++; $display("FAIL reset_no_capture got=%b exp=00", valid_o); end
        valid_i = '0;
        rst = 1'b0;
    endtask
    task automatic test_select();
        head_i = 3'd5;
        ready_i = 2'b11;
        valid_i = 2'b01;
        match_line_i[0] = 8'b0100_0010;
        tick();
        valid_i = 2'b00;
        match_line_i[0] = 'x;
        total++; if (valid_o !== 2'b01) begin bad++; $display("FAIL sel_valid got=%b exp=01", valid_o); end
        total++; if (match_o[0] !== 1'b1) begin bad++; $display("FAIL sel_match got=%b exp=1", match_o[0]); end
        total++; if (match_idx_o[0] !== 3'd1) begin bad++; $display("FAIL sel_idx got=%0d exp=1", match_idx_o[0]); end
`ifdef CAM_PRIO_MULTI_EN
        total++; if (multi_o[0] !== 1'b1) begin bad++; $display("FAIL sel_multi got=%b exp=1", multi_o[0]); end
`endif
        tick();
        total++; if (valid_o[0] !== 1'b0) begin bad++; $display("FAIL sel_drain got=%b exp=0", valid_o[0]); end
    endtask
    task automatic test_wrap();
        head_i = 3'd0;
        valid_i = 2'b01;
        match_line_i[0] = 8'h81;
        tick();
        total++; if (match_idx_o[0] !== 3'd7) begin bad++; $display("FAIL wrap_h0 got=%0d exp=7", match_idx_o[0]); end
        head_i = 3'd7;
        tick();
        total++; if (match_idx_o[0] !== 3'd0) begin bad++; $display("FAIL wrap_h7 got=%0d exp=0", match_idx_o[0]); end
        total++; if (match_o[0] !== 1'b1) begin bad++; $display("FAIL wrap_match got=%b exp=1", match_o[0]); end
        head_i = 3'd3;
        match_line_i[0] = 8'b0001_0100;
        tick();
        total++; if (match_idx_o[0] !== 3'd2) begin bad++; $display("FAIL wrap_h3 got=%0d exp=2", match_idx_o[0]); end
    endtask
    task automatic test_nohit();
        head_i = 3'd4;
        match_line_i[0] = 8'h00;
        tick();
        valid_i = 2'b00;
        total++; if (valid_o[0] !== 1'b1) begin bad++; $display("FAIL nohit_valid got=%b exp=1", valid_o[0]); end
        total++; if (match_o[0] !== 1'b0) begin bad++; $display("FAIL nohit_match got=%b exp=0", match_o[0]); end
        total++; if (match_idx_o[0] !== 3'd0) begin bad++; $display("FAIL nohit_idx got=%0d exp=0", match_idx_o[0]); end
`ifdef CAM_PRIO_MULTI_EN
        total++; if (multi_o[0] !== 1'b0) begin bad++; $display("FAIL nohit_multi got=%b exp=0", multi_o[0]); end
`endif
        tick();
    endtask
    task automatic test_back_to_back();
        head_i = 3'd0;
        valid_i = 2'b01;
        match_line_i[0] = 8'h14;
        tick();
        ready_i[0] = 1'b0;
        match_line_i[0] = 8'h08;
        head_i = 3'd2;
        #1;
        total++; if (ready_o[0] !== 1'b0) begin bad++; $display("FAIL stall_ready got=%b exp=0", ready_o[0]); end
        for (int c = 0; c < 3; c++) begin
            tick();
            total++; if (valid_o[0] !== 1'b1 || match_idx_o[0] !== 3'd4) begin bad++; $display("FAIL stall_hold%0d got=%b/%0d exp=1/4", c, valid_o[0], match_idx_o[0]); end
`ifdef CAM_PRIO_MULTI_EN
            total++; if (multi_o[0] !== 1'b1) begin bad++; $display("FAIL stall_multi%0d got=%b exp=1", c, multi_o[0]); end
`endif
        end
        ready_i[0] = 1'b1;
        #1;
        total++; if (ready_o[0] !== 1'b1) begin bad++; $display("FAIL release_ready got=%b exp=1", ready_o[0]); end
        tick();
        valid_i = 2'b00;
        total++; if (valid_o[0] !== 1'b1 || match_idx_o[0] !== 3'd3) begin bad++; $display("FAIL release_b got=%b/%0d exp=1/3", valid_o[0], match_idx_o[0]); end
        tick();
    endtask
    task automatic test_reset_stall();
        head_i = 3'd0;
        valid_i = 2'b01;
        match_line_i[0] = 8'h20;
        tick();
        valid_i = 2'b00;
        ready_i[0] = 1'b0;
        tick();
        total++; if (valid_o[0] !== 1'b1 || match_idx_o[0] !== 3'd5) begin bad++; $display("FAIL prestall got=%b/%0d exp=1/5", valid_o[0], match_idx_o[0]); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (valid_o[0] !== 1'b0) begin bad++; $display("FAIL rststall_valid got=%b exp=0", valid_o[0]); end
        total++; if (match_o[0] !== 1'b0 || match_idx_o[0] !== 3'd0) begin bad++; $display("FAIL rststall_fields got=%b/%0d exp=0/0", match_o[0], match_idx_o[0]); end
        total++; if (ready_o[0] !== 1'b1) begin bad++; $display("FAIL rststall_ready got=%b exp=1", ready_o[0]); end
    endtask
    task automatic test_independence();
        logic [7:0] vec [4];
        logic [2:0] exp [4];
        vec = '{8'h02, 8'h04, 8'h40, 8'h80};
        exp = '{3'd1, 3'd2, 3'd6, 3'd7};
        head_i = 3'd0;
        ready_i = 2'b11;
        valid_i = 2'b01;
        match_line_i[0] = 8'h01;
        tick();
        ready_i = 2'b10;
        valid_i = 2'b10;
        for (int k = 0; k < 4; k++) begin
            match_line_i[1] = vec[k];
            tick();
            total++; if (valid_o[1] !== 1'b1 || match_idx_o[1] !== exp[k]) begin bad++; $display("FAIL stream%0d got=%b/%0d exp=1/%0d", k, valid_o[1], match_idx_o[1], exp[k]); end
            total++; if (valid_o[0] !== 1'b1 || match_idx_o[0] !== 3'd0 || match_o[0] !== 1'b1) begin bad++; $display("FAIL p0_hold%0d got=%b/%b/%0d exp=1/1/0", k, valid_o[0], match_o[0], match_idx_o[0]); end
        end
        valid_i = 2'b00;
        tick();
        total++; if (valid_o !== 2'b01) begin bad++; $display("FAIL indep_end got=%b exp=01", valid_o); end
    endtask
    initial begin
        test_reset();
        test_select();
        test_wrap();
        test_nohit();
        test_back_to_back();
        test_reset_stall();
        test_independence();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
